// File: rtl/dcache_pkg.sv
// Shared types and default sizes for the data-cache backing memory stage.
// The request struct is sized by the package defaults.
package dcache_pkg;

    localparam int BLOCK_SIZE_DEF = 10;
    localparam int DATA_SIZE_DEF  = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic [BLOCK_SIZE_DEF-1:0] addr;
        logic [DATA_SIZE_DEF-1:0]  data;
        logic                      is_write;
    } mem_req_t;

endpackage

// File: rtl/dcache_main_mem_if.sv
// Memory-side bus between the data cache (master) and main memory (slave).
// Handshake: the master pulses rdEnMem or wrEnMem while memBusy==0; the slave
// raises memBusy until done, ignoring enables meanwhile, and a read ends with a
// one-cycle memValid pulse qualifying dataMem. Write wins if both enables are set.
interface dcache_main_mem_if #(
    parameter int BLOCK_SIZE = 10,
    parameter int DATA_SIZE  = 32
);
    logic [BLOCK_SIZE-1:0] rdAddrMem;
    logic [BLOCK_SIZE-1:0] wrAddrMem;
    logic [DATA_SIZE-1:0]  wrDataMem;
    logic                  rdEnMem;
    logic                  wrEnMem;
    logic [DATA_SIZE-1:0]  dataMem;
    logic                  memBusy;
    logic                  memValid;

    modport master (
        output rdAddrMem, wrAddrMem, wrDataMem, rdEnMem, wrEnMem,
        input  dataMem, memBusy, memValid
    );

    modport slave (
        input  rdAddrMem, wrAddrMem, wrDataMem, rdEnMem, wrEnMem,
        output dataMem, memBusy, memValid
    );
endinterface

// File: rtl/dcache_mem_array.sv
// Word store: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module dcache_mem_array #(
    parameter int BLOCK_SIZE = 10,
    parameter int DATA_SIZE  = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [BLOCK_SIZE-1:0] waddr,
    input  logic [DATA_SIZE-1:0]  wdata,
    input  logic [BLOCK_SIZE-1:0] raddr,
    output logic [DATA_SIZE-1:0]  rdata
);
    localparam int DEPTH = 1 << BLOCK_SIZE;

    logic [DATA_SIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/dcache_main_mem.sv
// Main memory behind the data cache: one request at a time, fixed read/write
// latencies, registered outputs only.
module dcache_main_mem
    import dcache_pkg::*;
#(
    parameter int BLOCK_SIZE = BLOCK_SIZE_DEF,
    parameter int DATA_SIZE  = DATA_SIZE_DEF,
    parameter int RD_LATENCY = 4,
    parameter int WR_LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    dcache_main_mem_if.slave bus,
    output mem_state_t state_dbg
);
    localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CNT_W   = ($clog2(MAX_LAT) > 0) ? $clog2(MAX_LAT) : 1;

    mem_state_t           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    mem_req_t             req_q, req_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic                 valid_q, valid_d;

    logic                 mem_we;
    logic [DATA_SIZE-1:0] mem_rdata;

    dcache_mem_array #(
        .BLOCK_SIZE(BLOCK_SIZE),
        .DATA_SIZE (DATA_SIZE)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .waddr(BLOCK_SIZE'(req_q.addr)),
        .wdata(DATA_SIZE'(req_q.data)),
        .raddr(BLOCK_SIZE'(req_q.addr)),
        .rdata(mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        data_d  = data_q;
        valid_d = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                // Write takes priority; a colliding read must be re-presented.
                if (bus.wrEnMem) begin
                    req_d.addr     = BLOCK_SIZE_DEF'(bus.wrAddrMem);
                    req_d.data     = DATA_SIZE_DEF'(bus.wrDataMem);
                    req_d.is_write = 1'b1;
                    cnt_d          = CNT_W'(WR_LATENCY - 1);
                    state_d        = WR_WAIT;
                end else if (bus.rdEnMem) begin
                    req_d.addr     = BLOCK_SIZE_DEF'(bus.rdAddrMem);
                    req_d.is_write = 1'b0;
                    cnt_d          = CNT_W'(RD_LATENCY - 1);
                    state_d        = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    data_d  = mem_rdata;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_WAIT: begin
                if (cnt_q == '0) begin
                    mem_we  = req_q.is_write;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset forces IDLE, so an in-flight write can never reach its commit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign bus.dataMem  = data_q;
    assign bus.memValid = valid_q;
    assign bus.memBusy  = (state_q != IDLE);
    assign state_dbg    = state_q;
endmodule

// File: doc/dcache_main_mem.md
Name: dcache_main_mem

Overview:
- Backing main-memory stage directly downstream of the data cache; it services the cache's miss fills and write-throughs on the memory-side bus.
- Single-ported word store of 2**BLOCK_SIZE words with fixed, parameterised read and write latencies.
- Handshake is busy/valid: one outstanding request at a time, no queuing.

Parameters:
- BLOCK_SIZE, 10, address width in words; store depth = 2**BLOCK_SIZE.
- DATA_SIZE, 32, data word width.
- RD_LATENCY, 4, cycles from read acceptance to the memValid pulse; legal range >= 1.
- WR_LATENCY, 2, cycles from write acceptance to commit and return to idle; legal range >= 1.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdAddrMem  in  BLOCK_SIZE  read word address.
- wrAddrMem  in  BLOCK_SIZE  write word address.
- wrDataMem  in  DATA_SIZE  write data. This is full data width, not address width.
- rdEnMem  in  1  read request.
- wrEnMem  in  1  write request.
- dataMem  out  DATA_SIZE  read return data; holds its value until the next read completes.
- memBusy  out  1  high while a request is in flight (state != IDLE).
- memValid  out  1  one-cycle pulse marking dataMem as new read data.

Behaviour:
- Clock/reset: one clock domain; rst is asynchronous and active-high.
- Reset values: state=IDLE, cnt=0, memBusy=0, memValid=0, dataMem=0. Store contents are not reset and are retained across rst.
- FSM states: IDLE, RD_WAIT, WR_WAIT. All outputs are registered or decoded from the registered state only; no input-to-output combinational path.
- Acceptance: a request is accepted at a rising edge only when state==IDLE and its enable is high.
- Read acceptance latches rdAddrMem and moves to RD_WAIT.
- Write acceptance latches wrAddrMem and wrDataMem and moves to WR_WAIT.
- On acceptance, cnt loads LATENCY-1.
- Simultaneous rdEnMem and wrEnMem in IDLE: the write wins. The read is not accepted; the requester must re-present it after memBusy falls.
- Enables seen in RD_WAIT or WR_WAIT are ignored, not queued. The requester pulses an enable for one cycle while memBusy==0. An enable held high re-triggers at the first IDLE edge after completion.
- RD_WAIT: if cnt==0, at that edge: dataMem <= store[latched addr], memValid <= 1, state <= IDLE. Otherwise cnt decrements.
  - Accept at edge N gives memValid high in the cycle after edge N+RD_LATENCY, for exactly one cycle.
  - memBusy is high in the cycles after edges N .. N+RD_LATENCY-1.
- WR_WAIT: if cnt==0, at that edge the store is written and state returns to IDLE. Otherwise cnt decrements.
  - The write is not visible before commit.
  - A read accepted in the IDLE cycle right after commit returns the new data.
- memValid is never asserted for writes.
- Back-to-back: a new request may be accepted at the same edge where memValid first becomes visible (state==IDLE in that cycle). Minimum read-to-read spacing is RD_LATENCY+1 edges.
- Address space is the full 2**BLOCK_SIZE; there is no out-of-range case. Address wrap is not applicable (single-word accesses).
- Reset mid-operation: an in-flight write is aborted and not committed. An in-flight read is dropped with no memValid. memBusy and memValid drop immediately (asynchronously).
- dataMem changes only on read completion or reset.

Decomposition:
- Shared package dcache_pkg holds:
  - BLOCK_SIZE and DATA_SIZE defaults.
  - mem_state_t enum {IDLE, RD_WAIT, WR_WAIT}.
  - mem_req_t struct {addr, data, is_write}, used by the latched request register.
- One sub-module, dcache_mem_array:
  - 2**BLOCK_SIZE x DATA_SIZE storage.
  - One synchronous write port (we, waddr, wdata).
  - One combinational read port (raddr -> rdata), no reset.
- The FSM, latency counter and output registers live in dcache_main_mem.

Test Plan:
- Reset/idle: assert rst mid-cycle -> memBusy=0, memValid=0, dataMem=0 immediately; no activity with enables low.
- Write then read, RD_LATENCY=4, WR_LATENCY=2:
  - Write 0xDEADBEEF to addr 0x1A5 at edge N -> memBusy high for 2 cycles.
  - Read 0x1A5 at the first IDLE edge M -> memValid pulse one cycle after edge M+4, dataMem=0xDEADBEEF, held after the pulse.
- Simultaneous rdEnMem=wrEnMem=1 in IDLE (wr addr 0x003 data 0x55, rd addr 0x004) -> only the write is accepted; no memValid. A later read of 0x003 returns 0x55.
- Request while busy:
  - Pulse rdEnMem at addr 0x010 during RD_WAIT of a read at 0x020 -> exactly one memValid, data from 0x020.
  - Pulse wrEnMem during WR_WAIT -> the store at that address is unchanged.
- Reset mid-operation:
  - Assert rst one cycle after accepting a write of 0x1234 to addr 0x2FF (old value 0x0) -> a later read returns 0x0.
  - Assert rst during RD_WAIT -> no memValid pulse ever appears for that read.
- Latency sweep RD_LATENCY=1 and WR_LATENCY=1:
  - Back-to-back reads of 0x000/0x3FF (preloaded 0xA, 0xB) -> memValid pulses 2 cycles apart, data 0xA then 0xB.
